// File: rtl/io_timer_pkg.sv
// ---------------------------------------------------------------------------
// io_timer_pkg
// Shared definitions for the io_timer peripheral: register offsets inside the
// 8-byte IO window, CTRL/STATUS bit positions, the packed CTRL register layout
// and the prescaler divisor decode.
// No ports (package).
// ---------------------------------------------------------------------------
package io_timer_pkg;

  // Register offsets within the IO window
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_CNT_L  = 3'd2;
  localparam logic [2:0] REG_CNT_H  = 3'd3;
  localparam logic [2:0] REG_CMP_L  = 3'd4;
  localparam logic [2:0] REG_CMP_H  = 3'd5;

  // CTRL bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_CTC    = 1;
  localparam int CTRL_MIE    = 2;
  localparam int CTRL_PS_LSB = 3;
  localparam int CTRL_OIE    = 6;

  // STATUS bit positions
  localparam int STAT_MATCH = 0;
  localparam int STAT_OVF   = 1;

  // CTRL register image; field order follows the bit layout MSB first
  typedef struct packed {
    logic       oie;
    logic [2:0] ps;
    logic       mie;
    logic       ctc;
    logic       en;
  } ctrl_t;

  // Prescale code to terminal count (divisor - 1)
  function automatic logic [9:0] psTerminal(input logic [2:0] code);
    logic [9:0] term;
    case (code)
      3'd0:    term = 10'd0;
      3'd1:    term = 10'd1;
      3'd2:    term = 10'd3;
      3'd3:    term = 10'd7;
      3'd4:    term = 10'd15;
      3'd5:    term = 10'd63;
      3'd6:    term = 10'd255;
      default: term = 10'd1023;
    endcase
    return term;
  endfunction

endpackage

// File: rtl/io_timer_prescaler.sv
// ---------------------------------------------------------------------------
// io_timer_prescaler
// 10-bit prescale counter that emits a one-cycle tick every divisor cycles.
// Ports:
//   clk     - system clock
//   reset   - synchronous, active-high reset
//   enable  - counter runs while high, held at 0 while low
//   restart - forces the counter back to 0 on the next edge
//   ps      - 3-bit prescale code (see psTerminal)
//   tick    - one-cycle pulse when the counter is at its terminal count
// ---------------------------------------------------------------------------
module io_timer_prescaler
  import io_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       restart,
  input  logic [2:0] ps,
  output logic       tick
);

  logic [9:0] count_q;
  logic [9:0] count_d;
  logic [9:0] terminal;

  assign terminal = psTerminal(ps);
  assign tick     = enable && (count_q == terminal);

  // Count up to the terminal value and wrap; any restart or disable parks at 0
  always_comb begin
    count_d = count_q + 10'd1;
    if (!enable || restart || tick) begin
      count_d = 10'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 10'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/io_timer.sv
// ---------------------------------------------------------------------------
// io_timer
// Memory-mapped 16-bit timer/counter with prescaler, clear-on-compare mode,
// sticky MATCH/OVF flags, atomic 16-bit count access and a level interrupt.
// Ports:
//   clk      - system clock
//   reset    - synchronous, active-high reset
//   cs       - decoded select for the 8-byte IO window
//   addr     - register offset
//   din      - write data
//   write_en - write strobe (qualified by cs)
//   read_en  - read strobe (qualified by cs)
//   dout     - registered read data, holds until the next read
//   irq      - level interrupt request
//   irq_clr  - interrupt acknowledge, clears the enabled flags
//   pwm_out  - PWM output (only with IO_TIMER_PWM_EN)
// Configuration macro: IO_TIMER_PWM_EN adds pwm_out and double-buffers CMP.
// ---------------------------------------------------------------------------
module io_timer
  import io_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  input  logic       write_en,
  input  logic       read_en,
  output logic [7:0] dout,
  output logic       irq,
  input  logic       irq_clr
`ifdef IO_TIMER_PWM_EN
  ,
  output logic       pwm_out
`endif
);

  ctrl_t       ctrl_q;
  ctrl_t       ctrl_d;
  logic [1:0]  flags_q;
  logic [1:0]  flags_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [15:0] cmp_q;
  logic [15:0] cmp_d;
  logic [7:0]  shadow_q;
  logic [7:0]  shadow_d;
  logic [7:0]  temp_q;
  logic [7:0]  temp_d;
  logic [7:0]  dout_q;
  logic [7:0]  dout_d;

  logic wr;
  logic rd;
  logic ctrlWr;
  logic statusWr;
  logic cntLWr;
  logic cntHWr;
  logic cmpLWr;
  logic cmpHWr;
  logic tickRaw;
  logic tick;
  logic cntEqCmp;
  logic ctcClear;
  logic hwMatch;
  logic hwOvf;

  assign wr       = cs && write_en;
  assign rd       = cs && read_en;
  assign ctrlWr   = wr && (addr == REG_CTRL);
  assign statusWr = wr && (addr == REG_STATUS);
  assign cntLWr   = wr && (addr == REG_CNT_L);
  assign cntHWr   = wr && (addr == REG_CNT_H);
  assign cmpLWr   = wr && (addr == REG_CMP_L);
  assign cmpHWr   = wr && (addr == REG_CMP_H);

  io_timer_prescaler u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .enable  (ctrl_q.en),
    .restart (ctrlWr || cntLWr),
    .ps      (ctrl_q.ps),
    .tick    (tickRaw)
  );

  // A CTRL write that turns the timer off swallows a tick landing on the same edge
  assign tick     = tickRaw && !(ctrlWr && !din[CTRL_EN]);
  assign cntEqCmp = (cnt_q == cmp_q);
  assign ctcClear = ctrl_q.ctc && cntEqCmp;
  assign hwMatch  = tick && cntEqCmp;
  assign hwOvf    = tick && (cnt_q == 16'hFFFF);

  assign irq  = (flags_q[STAT_MATCH] && ctrl_q.mie) || (flags_q[STAT_OVF] && ctrl_q.oie);
  assign dout = dout_q;

  // Control register and the CNT_H staging byte
  always_comb begin
    ctrl_d = ctrl_q;
    temp_d = temp_q;
    if (ctrlWr) begin
      ctrl_d.en  = din[CTRL_EN];
      ctrl_d.ctc = din[CTRL_CTC];
      ctrl_d.mie = din[CTRL_MIE];
      ctrl_d.ps  = din[CTRL_PS_LSB +: 3];
      ctrl_d.oie = din[CTRL_OIE];
    end
    if (cntHWr) begin
      temp_d = din;
    end
  end

  // Counter: a CNT_L load overrides the tick increment
  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = ctcClear ? 16'd0 : cnt_q + 16'd1;
    end
    if (cntLWr) begin
      cnt_d = {temp_q, din};
    end
  end

  // Sticky flags: software clears first, hardware sets last so they win
  always_comb begin
    flags_d = flags_q;
    if (statusWr) begin
      flags_d = flags_q & ~din[1:0];
    end
    if (irq_clr) begin
      if (ctrl_q.mie) flags_d[STAT_MATCH] = 1'b0;
      if (ctrl_q.oie) flags_d[STAT_OVF]   = 1'b0;
    end
    if (hwMatch) flags_d[STAT_MATCH] = 1'b1;
    if (hwOvf)   flags_d[STAT_OVF]   = 1'b1;
  end

  // Read path returns pre-edge values; a CNT_L read snapshots the high byte
  always_comb begin
    dout_d   = dout_q;
    shadow_d = shadow_q;
    if (rd) begin
      case (addr)
        REG_CTRL:   dout_d = {1'b0, ctrl_q};
        REG_STATUS: dout_d = {6'b0, flags_q};
        REG_CNT_L:  dout_d = cnt_q[7:0];
        REG_CNT_H:  dout_d = shadow_q;
        REG_CMP_L:  dout_d = cmp_q[7:0];
        REG_CMP_H:  dout_d = cmp_q[15:8];
        default:    dout_d = 8'h00;
      endcase
      if (addr == REG_CNT_L) begin
        shadow_d = cnt_q[15:8];
      end
    end
  end

`ifdef IO_TIMER_PWM_EN
  logic [15:0] cmpBuf_q;
  logic [15:0] cmpBuf_d;
  logic        pwm_q;
  logic        pwm_d;
  logic        wrapNow;

  // The count wraps to zero through CTC clear or 0xFFFF rollover, unless reloaded
  assign wrapNow = tick && (ctcClear || (cnt_q == 16'hFFFF)) && !cntLWr;

  // CMP writes land in the buffer; the active compare follows the buffer
  // while stopped and otherwise only at a wrap, so a period never tears
  always_comb begin
    cmpBuf_d = cmpBuf_q;
    if (cmpLWr) cmpBuf_d[7:0]  = din;
    if (cmpHWr) cmpBuf_d[15:8] = din;
    cmp_d = cmp_q;
    if (!ctrl_q.en) begin
      cmp_d = cmpBuf_d;
    end else if (wrapNow) begin
      cmp_d = cmpBuf_q;
    end
  end

  assign pwm_d   = ctrl_q.en && (cnt_q < cmp_q);
  assign pwm_out = pwm_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cmpBuf_q <= 16'd0;
      pwm_q    <= 1'b0;
    end else begin
      cmpBuf_q <= cmpBuf_d;
      pwm_q    <= pwm_d;
    end
  end
`else
  // Compare bytes are written straight into the active compare register
  always_comb begin
    cmp_d = cmp_q;
    if (cmpLWr) cmp_d[7:0]  = din;
    if (cmpHWr) cmp_d[15:8] = din;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= '0;
      flags_q  <= 2'b00;
      cnt_q    <= 16'd0;
      cmp_q    <= 16'd0;
      shadow_q <= 8'h00;
      temp_q   <= 8'h00;
      dout_q   <= 8'h00;
    end else begin
      ctrl_q   <= ctrl_d;
      flags_q  <= flags_d;
      cnt_q    <= cnt_d;
      cmp_q    <= cmp_d;
      shadow_q <= shadow_d;
      temp_q   <= temp_d;
      dout_q   <= dout_d;
    end
  end

endmodule

// File: tb/tb_io_timer.sv
// ---------------------------------------------------------------------------
// tb_io_timer
// Self-checking bench for io_timer. Each scenario task drives bus traffic,
// pushes the read data it expects onto a scoreboard queue and pops/compares
// when the registered read data appears. Inputs change on the falling edge,
// outputs are sampled on the falling edge after the sampling rising edge.
// ---------------------------------------------------------------------------
module tb_io_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs;
  logic [2:0] addr;
  logic [7:0] din;
  logic       write_en;
  logic       read_en;
  logic [7:0] dout;
  logic       irq;
  logic       irq_clr;
`ifdef IO_TIMER_PWM_EN
  logic       pwm_out;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] expQ[$];
  logic [7:0] got;
  logic [7:0] expv;

  io_timer dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .addr     (addr),
    .din      (din),
    .write_en (write_en),
    .read_en  (read_en),
    .dout     (dout),
    .irq      (irq),
    .irq_clr  (irq_clr)
`ifdef IO_TIMER_PWM_EN
    ,
    .pwm_out  (pwm_out)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // One write cycle, called and returning on a falling edge
  task automatic busWrite(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; write_en = 1'b1; addr = a; din = d;
    @(negedge clk);
    cs = 1'b0; write_en = 1'b0;
  endtask

  // One read cycle; returns the registered read data
  task automatic busRead(input logic [2:0] a, output logic [7:0] d);
    cs = 1'b1; read_en = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0; read_en = 1'b0;
    d = dout;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; cs = 1'b0; addr = 3'd0; din = 8'h00;
    write_en = 1'b0; read_en = 1'b0; irq_clr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) expQ.push_back(8'h00);
    for (int i = 0; i < 8; i++) begin
      busRead(3'(i), got);
      expv = expQ.pop_front();
      checks++;
      if (got !== expv) begin
        errors++;
        $display("[TB] FAIL reset_read%0d: dout=%h expected %h", i, got, expv);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_irq: irq=%b expected 0", irq);
    end
  endtask

  task automatic test_registers;
    busWrite(3'd4, 8'hA5);
    busWrite(3'd5, 8'h5A);
    busWrite(3'd0, 8'hBE);
    busWrite(3'd6, 8'hFF);
    busWrite(3'd7, 8'hFF);
    expQ.push_back(8'hA5);
    expQ.push_back(8'h5A);
    expQ.push_back(8'h3E);
    expQ.push_back(8'h00);
    expQ.push_back(8'h00);
    begin
      logic [2:0] rdAddr [5] = '{3'd4, 3'd5, 3'd0, 3'd6, 3'd7};
      for (int i = 0; i < 5; i++) begin
        busRead(rdAddr[i], got);
        expv = expQ.pop_front();
        checks++;
        if (got !== expv) begin
          errors++;
          $display("[TB] FAIL regs_read%0d: dout=%h expected %h", i, got, expv);
        end
      end
    end
    busWrite(3'd0, 8'h00);
  endtask

  task automatic test_ctc_match;
    busWrite(3'd4, 8'h05);
    busWrite(3'd5, 8'h00);
    busWrite(3'd0, 8'h07);
    idle(5);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ctc_irq_before: irq=%b expected 0", irq);
    end
    idle(1);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ctc_irq_match: irq=%b expected 1", irq);
    end
    expQ.push_back(8'h01);
    busRead(3'd1, got);
    expv = expQ.pop_front();
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL ctc_status: dout=%h expected %h", got, expv);
    end
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ctc_irq_clr: irq=%b expected 0", irq);
    end
    idle(3);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ctc_irq_gap: irq=%b expected 0", irq);
    end
    idle(1);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ctc_irq_rematch: irq=%b expected 1", irq);
    end
    busWrite(3'd0, 8'h00);
    busWrite(3'd1, 8'h03);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ctc_irq_off: irq=%b expected 0", irq);
    end
  endtask

  task automatic test_overflow;
    busWrite(3'd3, 8'hFF);
    busWrite(3'd2, 8'hFE);
    busWrite(3'd0, 8'h41);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_irq_start: irq=%b expected 0", irq);
    end
    idle(1);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_irq_ffff: irq=%b expected 0", irq);
    end
    idle(1);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_irq_wrap: irq=%b expected 1", irq);
    end
    expQ.push_back(8'h00);
    expQ.push_back(8'h00);
    expQ.push_back(8'h02);
    begin
      logic [2:0] rdAddr [3] = '{3'd2, 3'd3, 3'd1};
      for (int i = 0; i < 3; i++) begin
        busRead(rdAddr[i], got);
        expv = expQ.pop_front();
        checks++;
        if (got !== expv) begin
          errors++;
          $display("[TB] FAIL ovf_read%0d: dout=%h expected %h", i, got, expv);
        end
      end
    end
    busWrite(3'd1, 8'h02);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_w1c_irq: irq=%b expected 0", irq);
    end
    expQ.push_back(8'h00);
    busRead(3'd1, got);
    expv = expQ.pop_front();
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL ovf_w1c_status: dout=%h expected %h", got, expv);
    end
    busWrite(3'd0, 8'h00);
    busWrite(3'd1, 8'h03);
  endtask

  task automatic test_prescale;
    busWrite(3'd3, 8'h00);
    busWrite(3'd2, 8'h00);
    busWrite(3'd0, 8'h19);
    idle(7);
    expQ.push_back(8'h00);
    expQ.push_back(8'h01);
    for (int i = 0; i < 2; i++) begin
      busRead(3'd2, got);
      expv = expQ.pop_front();
      checks++;
      if (got !== expv) begin
        errors++;
        $display("[TB] FAIL ps_first%0d: dout=%h expected %h", i, got, expv);
      end
    end
    idle(6);
    expQ.push_back(8'h01);
    expQ.push_back(8'h02);
    for (int i = 0; i < 2; i++) begin
      busRead(3'd2, got);
      expv = expQ.pop_front();
      checks++;
      if (got !== expv) begin
        errors++;
        $display("[TB] FAIL ps_second%0d: dout=%h expected %h", i, got, expv);
      end
    end
    idle(2);
    busWrite(3'd0, 8'h19);
    idle(7);
    expQ.push_back(8'h02);
    expQ.push_back(8'h03);
    for (int i = 0; i < 2; i++) begin
      busRead(3'd2, got);
      expv = expQ.pop_front();
      checks++;
      if (got !== expv) begin
        errors++;
        $display("[TB] FAIL ps_restart%0d: dout=%h expected %h", i, got, expv);
      end
    end
    busWrite(3'd0, 8'h00);
    busWrite(3'd1, 8'h03);
  endtask

  task automatic test_atomic_read;
    busWrite(3'd3, 8'h12);
    busWrite(3'd2, 8'hFF);
    busWrite(3'd0, 8'h01);
    expQ.push_back(8'hFF);
    expQ.push_back(8'h12);
    expQ.push_back(8'h01);
    expQ.push_back(8'h13);
    for (int i = 0; i < 4; i++) begin
      busRead((i % 2 == 0) ? 3'd2 : 3'd3, got);
      expv = expQ.pop_front();
      checks++;
      if (got !== expv) begin
        errors++;
        $display("[TB] FAIL atomic_read%0d: dout=%h expected %h", i, got, expv);
      end
    end
    busWrite(3'd0, 8'h00);
    busWrite(3'd1, 8'h03);
  endtask

  task automatic test_precedence;
    busWrite(3'd4, 8'h00);
    busWrite(3'd5, 8'h00);
    busWrite(3'd3, 8'h00);
    busWrite(3'd2, 8'h00);
    busWrite(3'd0, 8'h07);
    idle(1);
    busWrite(3'd1, 8'h01);
    expQ.push_back(8'h01);
    busRead(3'd1, got);
    expv = expQ.pop_front();
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL prec_set_over_w1c: dout=%h expected %h", got, expv);
    end
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL prec_set_over_irqclr: irq=%b expected 1", irq);
    end
    busWrite(3'd0, 8'h00);
    busWrite(3'd1, 8'h01);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prec_cleared: irq=%b expected 0", irq);
    end
  endtask

`ifdef IO_TIMER_PWM_EN
  task automatic test_pwm;
    logic expBit;
    int highs;
    logic pwmQ[$];
    busWrite(3'd3, 8'h00);
    busWrite(3'd2, 8'h00);
    busWrite(3'd4, 8'h04);
    busWrite(3'd5, 8'h00);
    busWrite(3'd0, 8'h03);
    highs = 0;
    for (int k = 1; k <= 20; k++) pwmQ.push_back(((k - 1) % 5) < 4);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      expBit = pwmQ.pop_front();
      if (pwm_out === 1'b1) highs++;
      checks++;
      if (pwm_out !== expBit) begin
        errors++;
        $display("[TB] FAIL pwm_cycle%0d: pwm_out=%b expected %b", k, pwm_out, expBit);
      end
    end
    checks++;
    if (highs != 16) begin
      errors++;
      $display("[TB] FAIL pwm_duty: high=%0d expected 16", highs);
    end
    busWrite(3'd4, 8'h02);
    begin
      logic seq [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 11; i++) pwmQ.push_back(seq[i]);
    end
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      expBit = pwmQ.pop_front();
      checks++;
      if (pwm_out !== expBit) begin
        errors++;
        $display("[TB] FAIL pwm_newcmp%0d: pwm_out=%b expected %b", i, pwm_out, expBit);
      end
    end
    busWrite(3'd0, 8'h00);
    busWrite(3'd1, 8'h03);
  endtask
`endif

  task automatic test_reset_midcount;
    busWrite(3'd4, 8'h00);
    busWrite(3'd5, 8'h00);
    busWrite(3'd3, 8'h00);
    busWrite(3'd2, 8'h00);
    busWrite(3'd0, 8'h05);
    idle(4);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_irq_before: irq=%b expected 1", irq);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_irq_after: irq=%b expected 0", irq);
    end
    expQ.push_back(8'h00);
    expQ.push_back(8'h00);
    expQ.push_back(8'h00);
    begin
      logic [2:0] rdAddr [3] = '{3'd0, 3'd1, 3'd2};
      for (int i = 0; i < 3; i++) begin
        busRead(rdAddr[i], got);
        expv = expQ.pop_front();
        checks++;
        if (got !== expv) begin
          errors++;
          $display("[TB] FAIL midreset_read%0d: dout=%h expected %h", i, got, expv);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_registers();
    test_ctc_match();
    test_overflow();
    test_prescale();
    test_atomic_read();
    test_precedence();
`ifdef IO_TIMER_PWM_EN
    test_pwm();
`endif
    test_reset_midcount();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
